icg_ctrl_multi: RTL

ICG_CTRL_MULTI -- requirements
Module: icg_ctrl_multi

---
 rtl/icg_ctrl_multi.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/icg_ctrl_multi.sv
// -----------------------------------------------------------------------------
// icg_ctrl_multi
// Multi-channel integrated clock-gate controller. Each channel runs a small
// OFF/ON/HOLD state machine with an idle-hysteresis down-counter. The FSM
// drives a registered gate enable, and a low-transparent latch feeds an AND
// gate so that every gated clock is glitch-free.
//
// Parameters
//   N            channel count (1..32)
//   IDLE_CYCLES  idle cycles tolerated before a channel's gate closes (0..255)
//
// Ports
//   CLK   in   1  rising-edge clock; source of every gated clock
//   RN    in   1  synchronous active-low reset
//   E     in   N  per-channel activity request
//   TE    in   1  test enable; forces every gated clock open (FSMs unaffected)
//   EN    out  N  registered gate enable (ON or HOLD)
//   Q     out  N  gated clocks
//   ACK   out  N  registered "gated clock running" acknowledge
//   IDLE  out  1  registered; high when every channel is OFF
// -----------------------------------------------------------------------------
module icg_ctrl_multi #(
  parameter int N           = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic [N-1:0] E,
  input  logic         TE,
  output logic [N-1:0] EN,
  output logic [N-1:0] Q,
  output logic [N-1:0] ACK,
  output logic         IDLE
);

  // IDLE_CYCLES=0 still needs a one-bit counter so the declarations stay legal.
  localparam int CW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  state_e          state_q [N];
  state_e          state_d [N];
  logic [CW-1:0]   cnt_q   [N];
  logic [CW-1:0]   cnt_d   [N];
  logic [N-1:0]    en_q,  en_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            idle_q, idle_d;
  logic [N-1:0]    lat_q;

  // Next-state, counter and registered-output logic for every channel.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          cnt_d[i] = CNT_ZERO;
          if (E[i]) begin
            state_d[i] = ST_ON;
          end else begin
            state_d[i] = ST_OFF;
          end
        end
        ST_ON: begin
          if (E[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = CNT_ZERO;
          end else if (IDLE_CYCLES == 0) begin
            // No hysteresis: the gate closes on the first idle edge.
            state_d[i] = ST_OFF;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        ST_HOLD: begin
          if (E[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_ZERO) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = cnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
      en_d[i]  = (state_d[i] != ST_OFF);
      // ACK rises one edge after EN but drops together with it.
      ack_d[i] = en_q[i] & en_d[i];
    end
    idle_d = ~(|en_d);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= CNT_ZERO;
      end
      en_q   <= {N{1'b0}};
      ack_q  <= {N{1'b0}};
      idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q   <= en_d;
      ack_q  <= ack_d;
      idle_q <= idle_d;
    end
  end

  // Gate latch: transparent while CLK is low so enable changes launched at a
  // rising edge only reach the AND gate after the current high phase ends.
  always_latch begin
    if (!CLK) begin
      lat_q <= en_q | {N{TE}};
    end
  end

  assign Q    = {N{CLK}} & lat_q;
  assign EN   = en_q;
  assign ACK  = ack_q;
  assign IDLE = idle_q;

endmodule
